// File: rtl/zbus_strobe_filter_if.sv
// Z80 control-strobe bundle: the raw asynchronous strobes going in, and the filtered
// strobes plus access-event pulses coming out.
interface zbus_strobe_filter_if;
    logic       ziorq_n;
    logic       zmreq_n;
    logic       zrd_n;
    logic       zwr_n;
    logic       fiorq_n;
    logic       fmreq_n;
    logic       frd_n;
    logic       fwr_n;
    logic       io_rd_beg;
    logic       io_wr_beg;
    logic       mem_rd_beg;
    logic       mem_wr_beg;
    logic       acc_end;
    logic       acc_active;
    logic [1:0] acc_type;
    logic       bus_err;

    modport master (
        output ziorq_n, zmreq_n, zrd_n, zwr_n,
        input  fiorq_n, fmreq_n, frd_n, fwr_n,
        input  io_rd_beg, io_wr_beg, mem_rd_beg, mem_wr_beg,
        input  acc_end, acc_active, acc_type, bus_err
    );

    modport slave (
        input  ziorq_n, zmreq_n, zrd_n, zwr_n,
        output fiorq_n, fmreq_n, frd_n, fwr_n,
        output io_rd_beg, io_wr_beg, mem_rd_beg, mem_wr_beg,
        output acc_end, acc_active, acc_type, bus_err
    );
endinterface

// File: rtl/zbus_strobe_filter.sv
// Synchronises and deglitches the Z80 strobes on fclk, then classifies each bus access
// and emits single-cycle begin/end/error pulses for the address decoder and sequencer.
module zbus_strobe_filter #(
    parameter int FILT_LEN = 3,
    parameter int CNT_W    = 3
) (
    input logic                fclk,
    input logic                rst,
    zbus_strobe_filter_if.slave bus
);
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, IORD, IOWR, MEMRD, MEMWR} state_e;

    localparam int IO = 3, MR = 2, RD = 1, WR = 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic [3:0]       raw, s1, s2, filt;
    logic [CNT_W-1:0] cnt [4];

    assign raw = {bus.ziorq_n, bus.zmreq_n, bus.zrd_n, bus.zwr_n};

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fclk) begin
        if (rst) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // A level change must persist for FILT_LEN synchronised samples before it reaches filt.
    always_ff @(posedge fclk) begin
        if (rst) begin
            filt <= '1;
            // NOTE: the counters are a handful of flops, not a RAM, so resetting them is cheap and safe.
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    logic io_l, mr_l, rd_l, wr_l;
    assign io_l = !filt[IO];
    assign mr_l = !filt[MR];
    assign rd_l = !filt[RD];
    assign wr_l = !filt[WR];

    state_e     state_q, state_d;
    logic       armed_q;
    logic [1:0] type_q, type_d;
    logic [3:0] beg_q, beg_d;
    logic       end_q, end_d, err_q, err_d;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        beg_d   = '0;
        end_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            // Registers all read high straight out of reset, so the exit also waits one
            // cycle and requires both synchroniser stages high; strobes held low across
            // reset release therefore cannot slip through as a phantom access.
            WAIT_IDLE: if (armed_q && (&s1) && (&s2) && (&filt)) state_d = IDLE;
            IDLE: begin
                if ((rd_l && wr_l) || (io_l && mr_l && (rd_l || wr_l))) begin
                    err_d   = 1'b1;
                    state_d = WAIT_IDLE;
                end else if (io_l && rd_l) begin
                    state_d = IORD;  type_d = 2'b00; beg_d[0] = 1'b1;
                end else if (io_l && wr_l) begin
                    state_d = IOWR;  type_d = 2'b01; beg_d[1] = 1'b1;
                end else if (mr_l && rd_l) begin
                    state_d = MEMRD; type_d = 2'b10; beg_d[2] = 1'b1;
                end else if (mr_l && wr_l) begin
                    state_d = MEMWR; type_d = 2'b11; beg_d[3] = 1'b1;
                end
            end
            IORD:  if (!(io_l && rd_l)) begin state_d = IDLE; end_d = 1'b1; end
            IOWR:  if (!(io_l && wr_l)) begin state_d = IDLE; end_d = 1'b1; end
            MEMRD: if (!(mr_l && rd_l)) begin state_d = IDLE; end_d = 1'b1; end
            MEMWR: if (!(mr_l && wr_l)) begin state_d = IDLE; end_d = 1'b1; end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q <= WAIT_IDLE;
            armed_q <= 1'b0;
            type_q  <= 2'b00;
            beg_q   <= '0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            type_q  <= type_d;
            beg_q   <= beg_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

    assign bus.fiorq_n    = filt[IO];
    assign bus.fmreq_n    = filt[MR];
    assign bus.frd_n      = filt[RD];
    assign bus.fwr_n      = filt[WR];
    assign bus.io_rd_beg  = beg_q[0];
    assign bus.io_wr_beg  = beg_q[1];
    assign bus.mem_rd_beg = beg_q[2];
    assign bus.mem_wr_beg = beg_q[3];
    assign bus.acc_end    = end_q;
    assign bus.bus_err    = err_q;
    assign bus.acc_active = (state_q == IORD) || (state_q == IOWR) ||
                            (state_q == MEMRD) || (state_q == MEMWR);
    assign bus.acc_type   = type_q;
endmodule
